// File: rtl/pixel_write_buffer_pkg.sv
// Shared definitions for the painter-to-framebuffer write path: screen geometry
// widths, framebuffer address width, drain FSM encodings and the queued pixel record.
package pixel_write_buffer_pkg;

    localparam int SCR_WIDTH_BITS  = 8;
    localparam int SCR_HEIGHT_BITS = 7;
    localparam int COLOR_SIZE      = 3;
    localparam int FB_ADDR_BITS    = SCR_WIDTH_BITS + SCR_HEIGHT_BITS;

    typedef enum logic [1:0] {
        PWB_IDLE  = 2'd0,
        PWB_WRITE = 2'd1,
        PWB_CLEAR = 2'd2
    } pwb_state_e;

    typedef struct packed {
        logic [SCR_WIDTH_BITS-1:0]  x;
        logic [SCR_HEIGHT_BITS-1:0] y;
        logic [COLOR_SIZE-1:0]      color;
    } pixel_t;

    // Linear framebuffer address y*w + x, unsigned at full address width.
    function automatic logic [FB_ADDR_BITS-1:0] lin_addr(
        input logic [SCR_WIDTH_BITS-1:0]  x,
        input logic [SCR_HEIGHT_BITS-1:0] y,
        input int unsigned                w
    );
        return FB_ADDR_BITS'(y) * FB_ADDR_BITS'(w) + FB_ADDR_BITS'(x);
    endfunction

endpackage

// File: rtl/pixel_write_buffer_fifo.sv
// Small synchronous pixel FIFO. A push while full is dropped unless a pop happens
// in the same cycle, in which case both take effect and the count is unchanged.
// The head is read combinationally so the drain FSM can pop straight into its
// output registers.
module pixel_fifo
    import pixel_write_buffer_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   Clck,
    input  logic                   Reset,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  pixel_t                 din_i,
    output pixel_t                 dout_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PW = $clog2(DEPTH);

    pixel_t          mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [PW:0]     count_q;
    logic            do_push;
    logic            do_pop;

    assign full_o  = (count_q == (PW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Storage array: written on accepted pushes, no reset needed for contents.
    always_ff @(posedge Clck) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
    always_ff @(posedge Clck) begin
        if (!Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/pixel_write_buffer.sv
// Captures each painted pixel on the rising edge of print_enable, clips it to the
// screen, queues it and drains it to the framebuffer with a valid/ready handshake.
// Define PIXEL_BUFFER_CLEAR_EN to sweep the whole screen with CLEAR_COLOR after reset.
module pixel_write_buffer
    import pixel_write_buffer_pkg::*;
#(
    parameter int SCR_W = 160,
    parameter int SCR_H = 120,
    parameter int DEPTH = 8
`ifdef PIXEL_BUFFER_CLEAR_EN
    ,
    parameter logic [COLOR_SIZE-1:0] CLEAR_COLOR = 3'b000
`endif
) (
    input  logic                       Clck,
    input  logic                       Reset,
    input  logic [SCR_WIDTH_BITS-1:0]  paint_x_co,
    input  logic [SCR_HEIGHT_BITS-1:0] paint_y_co,
    input  logic [COLOR_SIZE-1:0]      color,
    input  logic                       print_enable,
    input  logic                       fb_ready,
    output logic                       fb_we,
    output logic [SCR_WIDTH_BITS-1:0]  fb_x,
    output logic [SCR_HEIGHT_BITS-1:0] fb_y,
    output logic [FB_ADDR_BITS-1:0]    fb_addr,
    output logic [COLOR_SIZE-1:0]      fb_color,
    output logic                       busy,
    output logic                       overflow
);

    pwb_state_e                 state_q, state_d;
    logic                       pe_q;
    logic                       overflow_q;
    logic                       fb_we_q, fb_we_d;
    logic [SCR_WIDTH_BITS-1:0]  fb_x_q, fb_x_d;
    logic [SCR_HEIGHT_BITS-1:0] fb_y_q, fb_y_d;
    logic [FB_ADDR_BITS-1:0]    fb_addr_q, fb_addr_d;
    logic [COLOR_SIZE-1:0]      fb_color_q, fb_color_d;

    logic                       push_req;
    logic                       pop;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic [$clog2(DEPTH):0]     fifo_count;
    pixel_t                     head;
    pixel_t                     in_pix;

    // Only the first cycle of a strobe pushes, and only on-screen pixels.
    assign push_req = print_enable && !pe_q
                   && (int'(paint_x_co) < SCR_W) && (int'(paint_y_co) < SCR_H);
    assign in_pix   = '{x: paint_x_co, y: paint_y_co, color: color};

    pixel_fifo #(.DEPTH(DEPTH)) u_fifo (
        .Clck    (Clck),
        .Reset   (Reset),
        .push_i  (push_req),
        .pop_i   (pop),
        .din_i   (in_pix),
        .dout_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign fb_we    = fb_we_q;
    assign fb_x     = fb_x_q;
    assign fb_y     = fb_y_q;
    assign fb_addr  = fb_addr_q;
    assign fb_color = fb_color_q;
    assign overflow = overflow_q;
    assign busy     = (fifo_count != '0) || fb_we_q || (state_q == PWB_CLEAR);

    // Drain FSM: pop into the output registers whenever the current write is
    // absent or being accepted, so a full FIFO streams out at one pixel per cycle.
    always_comb begin
        state_d    = state_q;
        pop        = 1'b0;
        fb_we_d    = fb_we_q;
        fb_x_d     = fb_x_q;
        fb_y_d     = fb_y_q;
        fb_addr_d  = fb_addr_q;
        fb_color_d = fb_color_q;
        case (state_q)
            PWB_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    fb_we_d    = 1'b1;
                    fb_x_d     = head.x;
                    fb_y_d     = head.y;
                    fb_color_d = head.color;
                    fb_addr_d  = lin_addr(head.x, head.y, SCR_W);
                    state_d    = PWB_WRITE;
                end
            end
            PWB_WRITE: begin
                if (fb_ready) begin
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        fb_x_d     = head.x;
                        fb_y_d     = head.y;
                        fb_color_d = head.color;
                        fb_addr_d  = lin_addr(head.x, head.y, SCR_W);
                    end else begin
                        fb_we_d = 1'b0;
                        state_d = PWB_IDLE;
                    end
                end
            end
`ifdef PIXEL_BUFFER_CLEAR_EN
            PWB_CLEAR: begin
                if (!fb_we_q) begin
                    // First cycle after reset: present pixel (0,0).
                    fb_we_d    = 1'b1;
                    fb_x_d     = '0;
                    fb_y_d     = '0;
                    fb_addr_d  = '0;
                    fb_color_d = CLEAR_COLOR;
                end else if (fb_ready) begin
                    if (int'(fb_x_q) == SCR_W-1 && int'(fb_y_q) == SCR_H-1) begin
                        if (!fifo_empty) begin
                            pop        = 1'b1;
                            fb_x_d     = head.x;
                            fb_y_d     = head.y;
                            fb_color_d = head.color;
                            fb_addr_d  = lin_addr(head.x, head.y, SCR_W);
                            state_d    = PWB_WRITE;
                        end else begin
                            fb_we_d = 1'b0;
                            state_d = PWB_IDLE;
                        end
                    end else if (int'(fb_x_q) == SCR_W-1) begin
                        fb_x_d    = '0;
                        fb_y_d    = fb_y_q + 1'b1;
                        fb_addr_d = fb_addr_q + 1'b1;
                    end else begin
                        fb_x_d    = fb_x_q + 1'b1;
                        fb_addr_d = fb_addr_q + 1'b1;
                    end
                end
            end
`endif
            default: begin
                fb_we_d = 1'b0;
                state_d = PWB_IDLE;
            end
        endcase
    end

    // State, output registers, edge-detect register and sticky overflow flag.
    always_ff @(posedge Clck) begin
        if (!Reset) begin
`ifdef PIXEL_BUFFER_CLEAR_EN
            state_q <= PWB_CLEAR;
`else
            state_q <= PWB_IDLE;
`endif
            pe_q       <= 1'b0;
            overflow_q <= 1'b0;
            fb_we_q    <= 1'b0;
            fb_x_q     <= '0;
            fb_y_q     <= '0;
            fb_addr_q  <= '0;
            fb_color_q <= '0;
        end else begin
            state_q    <= state_d;
            pe_q       <= print_enable;
            fb_we_q    <= fb_we_d;
            fb_x_q     <= fb_x_d;
            fb_y_q     <= fb_y_d;
            fb_addr_q  <= fb_addr_d;
            fb_color_q <= fb_color_d;
            if (push_req && fifo_full && !pop) begin
                overflow_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pixel_write_buffer.sv
// Self-checking bench for pixel_write_buffer: expected writes are queued when a
// pixel is driven and compared by a monitor as each handshake completes.
module tb_pixel_write_buffer;
    import pixel_write_buffer_pkg::*;

`ifdef PIXEL_BUFFER_CLEAR_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    logic                       Clck = 1'b0;
    logic                       Reset = 1'b0;
    logic [SCR_WIDTH_BITS-1:0]  paint_x_co = '0;
    logic [SCR_HEIGHT_BITS-1:0] paint_y_co = '0;
    logic [COLOR_SIZE-1:0]      color = '0;
    logic                       print_enable = 1'b0;
    logic                       fb_ready = 1'b0;
    logic                       fb_we;
    logic [SCR_WIDTH_BITS-1:0]  fb_x;
    logic [SCR_HEIGHT_BITS-1:0] fb_y;
    logic [FB_ADDR_BITS-1:0]    fb_addr;
    logic [COLOR_SIZE-1:0]      fb_color;
    logic                       busy;
    logic                       overflow;

    pixel_write_buffer dut (
        .Clck         (Clck),
        .Reset        (Reset),
        .paint_x_co   (paint_x_co),
        .paint_y_co   (paint_y_co),
        .color        (color),
        .print_enable (print_enable),
        .fb_ready     (fb_ready),
        .fb_we        (fb_we),
        .fb_x         (fb_x),
        .fb_y         (fb_y),
        .fb_addr      (fb_addr),
        .fb_color     (fb_color),
        .busy         (busy),
        .overflow     (overflow)
    );

    always #5 Clck = ~Clck;

    typedef struct {
        logic [7:0]  x;
        logic [6:0]  y;
        logic [2:0]  c;
        logic [14:0] addr;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   writes = 0;
    bit   mon_en = 1'b0;

    // Scoreboard monitor: every accepted write must match the oldest expectation.
    always @(negedge Clck) begin
        exp_t e;
        if (mon_en && Reset && fb_we && fb_ready) begin
            writes++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got x=%0d y=%0d addr=%0d, required no write", fb_x, fb_y, fb_addr);
            end else begin
                e = sb.pop_front();
                if (fb_x !== e.x || fb_y !== e.y || fb_color !== e.c || fb_addr !== e.addr) begin
                    errors++;
                    $display("FAIL write_data: got x=%0d y=%0d c=%0d addr=%0d, required x=%0d y=%0d c=%0d addr=%0d",
                             fb_x, fb_y, fb_color, fb_addr, e.x, e.y, e.c, e.addr);
                end else begin
                    $display("write x=%0d y=%0d color=%0d addr=%0d", fb_x, fb_y, fb_color, fb_addr);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge Clck);
        #1;
    endtask

    task automatic expect_pixel(input int x, input int y, input int c);
        exp_t e;
        e.x = 8'(x); e.y = 7'(y); e.c = 3'(c);
        e.addr = 15'(y * 160 + x);
        sb.push_back(e);
    endtask

    // One painter strobe: 3 cycles high, 3 low. Called just after a rising edge.
    task automatic pulse(input int x, input int y, input int c, input bit accepted);
        paint_x_co = 8'(x); paint_y_co = 7'(y); color = 3'(c);
        print_enable = 1'b1;
        if (accepted) expect_pixel(x, y, c);
        tick(3);
        print_enable = 1'b0;
        tick(3);
    endtask

    task automatic drain(input string name);
        fb_ready = 1'b1;
        for (int k = 0; k < 100 && busy; k++) @(negedge Clck);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_drain_timeout: got busy=%0b, required 0", name, busy);
        end
        tick(1);
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        tick(2);
        @(negedge Clck);
        checks += 7;
        if (fb_we !== 1'b0)     begin errors++; $display("FAIL reset_we: got %0b, required 0", fb_we); end
        if (fb_x !== '0)        begin errors++; $display("FAIL reset_x: got %0d, required 0", fb_x); end
        if (fb_y !== '0)        begin errors++; $display("FAIL reset_y: got %0d, required 0", fb_y); end
        if (fb_addr !== '0)     begin errors++; $display("FAIL reset_addr: got %0d, required 0", fb_addr); end
        if (fb_color !== '0)    begin errors++; $display("FAIL reset_color: got %0d, required 0", fb_color); end
        if (overflow !== 1'b0)  begin errors++; $display("FAIL reset_overflow: got %0b, required 0", overflow); end
        if (busy !== CLR)       begin errors++; $display("FAIL reset_busy: got %0b, required %0b", busy, CLR); end
        @(posedge Clck); #1;
        Reset = 1'b1;
        mon_en = 1'b1;
    endtask

`ifdef PIXEL_BUFFER_CLEAR_EN
    task automatic test_clear();
        int n;
        int last;
        n = 0; last = -1;
        mon_en = 1'b0;
        fb_ready = 1'b1;
        for (int k = 0; k < 20000 && busy; k++) begin
            @(negedge Clck);
            if (fb_we && fb_ready) begin
                checks++;
                if (fb_addr !== 15'(n) || fb_color !== 3'b000) begin
                    errors++;
                    $display("FAIL clear_pixel: got addr=%0d color=%0d, required addr=%0d color=0", fb_addr, fb_color, n);
                end
                last = int'(fb_addr);
                n++;
            end
        end
        checks += 2;
        if (n != 19200)   begin errors++; $display("FAIL clear_count: got %0d, required 19200", n); end
        if (last != 19199) begin errors++; $display("FAIL clear_last_addr: got %0d, required 19199", last); end
        $display("clear sweep writes=%0d last_addr=%0d", n, last);
        tick(1);
        mon_en = 1'b1;
    endtask
`endif

    task automatic test_single();
        int w0;
        w0 = writes;
        fb_ready = 1'b1;
        paint_x_co = 8'd5; paint_y_co = 7'd7; color = 3'b010;
        print_enable = 1'b1;
        expect_pixel(5, 7, 2);
        @(posedge Clck);            // edge N: push
        @(negedge Clck);
        checks++;
        if (fb_we !== 1'b0) begin errors++; $display("FAIL single_we_at_N: got %0b, required 0", fb_we); end
        @(posedge Clck);            // edge N+1: output loaded
        @(negedge Clck);
        checks += 3;
        if (fb_we !== 1'b1)        begin errors++; $display("FAIL single_we_at_N1: got %0b, required 1", fb_we); end
        if (fb_addr !== 15'd1125)  begin errors++; $display("FAIL single_addr: got %0d, required 1125", fb_addr); end
        if (fb_color !== 3'b010)   begin errors++; $display("FAIL single_color: got %0d, required 2", fb_color); end
        @(posedge Clck); #1;        // edge N+2: write accepted
        print_enable = 1'b0;
        @(negedge Clck);
        checks++;
        if (fb_we !== 1'b0) begin errors++; $display("FAIL single_we_at_N2: got %0b, required 0", fb_we); end
        tick(6);
        checks++;
        if (writes - w0 != 1) begin errors++; $display("FAIL single_write_count: got %0d, required 1", writes - w0); end
    endtask

    task automatic test_clip();
        int w0;
        bit bad;
        w0 = writes;
        fb_ready = 1'b1;
        bad = 1'b0;
        for (int p = 0; p < 2; p++) begin
            paint_x_co = (p == 0) ? 8'd160 : 8'd0;
            paint_y_co = (p == 0) ? 7'd0 : 7'd120;
            color = 3'b111;
            print_enable = 1'b1;
            for (int k = 0; k < 6; k++) begin
                @(negedge Clck);
                if (busy !== 1'b0 || fb_we !== 1'b0) bad = 1'b1;
                @(posedge Clck); #1;
                if (k == 2) print_enable = 1'b0;
            end
        end
        checks += 2;
        if (bad)              begin errors++; $display("FAIL clip_busy: got busy/we high, required 0"); end
        if (writes != w0)     begin errors++; $display("FAIL clip_writes: got %0d, required 0", writes - w0); end
    endtask

    task automatic test_back_to_back();
        fb_ready = 1'b0;
        for (int i = 0; i < 3; i++) pulse(30 + i, 40 + i, i + 1, 1'b1);
        fb_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge Clck);
            checks++;
            if (fb_we !== (k < 3)) begin
                errors++;
                $display("FAIL b2b_we_cycle%0d: got %0b, required %0b", k, fb_we, (k < 3));
            end
        end
        tick(1);
    endtask

    task automatic test_full_pushpop();
        int w0;
        w0 = writes;
        fb_ready = 1'b0;
        for (int i = 0; i < 9; i++) pulse(50 + i, 60 + i, i, 1'b1);
        // One in the output register, eight queued: FIFO is full.
        paint_x_co = 8'd20; paint_y_co = 7'd30; color = 3'b101;
        print_enable = 1'b1;
        fb_ready = 1'b1;
        expect_pixel(20, 30, 5);
        @(posedge Clck); #1;        // push and pop together
        fb_ready = 1'b0;
        @(negedge Clck);
        checks += 2;
        if (dut.u_fifo.count_q !== 4'd8) begin errors++; $display("FAIL pushpop_count: got %0d, required 8", dut.u_fifo.count_q); end
        if (overflow !== 1'b0)           begin errors++; $display("FAIL pushpop_overflow: got %0b, required 0", overflow); end
        tick(2);
        print_enable = 1'b0;
        tick(3);
        drain("pushpop");
        checks += 3;
        if (writes - w0 != 10) begin errors++; $display("FAIL pushpop_writes: got %0d, required 10", writes - w0); end
        if (sb.size() != 0)    begin errors++; $display("FAIL pushpop_pending: got %0d, required 0", sb.size()); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL pushpop_overflow_end: got %0b, required 0", overflow); end
    endtask

    task automatic test_overflow();
        int w0;
        w0 = writes;
        fb_ready = 1'b0;
        // 1 latched + 8 queued; the 10th pulse finds the FIFO full and is dropped.
        for (int i = 0; i < 10; i++) pulse(10 + i, 1 + i, i % 8, i < 9);
        checks += 2;
        if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %0b, required 1", overflow); end
        if (fb_we !== 1'b1)    begin errors++; $display("FAIL ovf_stalled_we: got %0b, required 1", fb_we); end
        drain("ovf");
        checks += 3;
        if (writes - w0 != 9)  begin errors++; $display("FAIL ovf_writes: got %0d, required 9", writes - w0); end
        if (sb.size() != 0)    begin errors++; $display("FAIL ovf_pending: got %0d, required 0", sb.size()); end
        if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %0b, required 1", overflow); end
    endtask

    task automatic test_reset_mid();
        fb_ready = 1'b0;
        for (int i = 0; i < 4; i++) pulse(100 + i, 90 + i, 7 - i, 1'b1);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL rmid_busy_before: got %0b, required 1", busy); end
        Reset = 1'b0;
        @(posedge Clck);
        @(negedge Clck);
        checks += 3;
        if (fb_we !== 1'b0)    begin errors++; $display("FAIL rmid_we: got %0b, required 0", fb_we); end
        if (busy !== CLR)      begin errors++; $display("FAIL rmid_busy: got %0b, required %0b", busy, CLR); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL rmid_overflow: got %0b, required 0", overflow); end
        sb.delete();
        @(posedge Clck); #1;
        Reset = 1'b1;
        tick(3);
        checks++;
        if (!CLR && fb_we !== 1'b0) begin errors++; $display("FAIL rmid_no_resume: got %0b, required 0", fb_we); end
    endtask

    initial begin
        test_reset();
`ifdef PIXEL_BUFFER_CLEAR_EN
        test_clear();
`endif
        test_single();
        test_clip();
        test_back_to_back();
        test_full_pushpop();
        test_overflow();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
